// File: rtl/note_player_if.sv
// note_player_if
//   Groups the sequencer's control inputs and audio/status outputs into one
//   bundle. The clock and reset stay plain ports on the module.
//
//   play      controller -> player   level, start request
//   stop      controller -> player   level, abort request
//   note_data memory     -> player   [7:4] pitch code, [3:0] beats (0 = 16)
//   finish    counter    -> player   address counter wrapped past the last note
//   read      player     -> counter  one-cycle advance strobe
//   listen    player     -> counter  one-cycle rewind strobe
//   tone_out  player     -> audio    square wave
//   busy      player     -> status   high whenever not idle
//   done      player     -> status   one-cycle end-of-song pulse
interface note_player_if;
  logic       play;
  logic       stop;
  logic [7:0] note_data;
  logic       finish;
  logic       read;
  logic       listen;
  logic       tone_out;
  logic       busy;
  logic       done;

  modport master (
    output play, stop, note_data, finish,
    input  read, listen, tone_out, busy, done
  );

  modport slave (
    input  play, stop, note_data, finish,
    output read, listen, tone_out, busy, done
  );
endinterface

// File: rtl/note_player.sv
// note_player
//   Plays the song stored behind the note-address counter. Each note word is
//   fetched MEM_LAT cycles after a read/listen strobe, played as a square wave
//   for its duration, followed by a silent articulation gap, then the next
//   address is requested. The song ends when the counter reports finish.
//
//   Ports
//     clock  rising-edge system clock
//     reset  synchronous, active-low
//     np     note_player_if.slave (play, stop, note_data, finish in;
//            read, listen, tone_out, busy, done out)
//
//   Build option
//     NOTE_PLAYER_LOOP_EN  when defined, a finish indication rewinds the
//                          counter and replays the song instead of ending it.
module note_player #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int MEM_LAT     = 2
) (
  input  logic        clock,
  input  logic        reset,
  note_player_if.slave np
);

  localparam int FW       = $clog2(MEM_LAT + 1);
  localparam int BW       = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int HALF_MAX = CLK_FREQ / (2 * 262);
  localparam int TW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    PLAY    = 3'd2,
    GAP     = 3'd3,
    ADVANCE = 3'd4
  } state_t;

  // Pitch code to frequency in Hz; code 0 is a rest.
  function automatic int note_freq(input logic [3:0] code);
    case (code)
      4'd1:    note_freq = 262;
      4'd2:    note_freq = 277;
      4'd3:    note_freq = 294;
      4'd4:    note_freq = 311;
      4'd5:    note_freq = 330;
      4'd6:    note_freq = 349;
      4'd7:    note_freq = 370;
      4'd8:    note_freq = 392;
      4'd9:    note_freq = 415;
      4'd10:   note_freq = 440;
      4'd11:   note_freq = 466;
      4'd12:   note_freq = 494;
      4'd13:   note_freq = 523;
      4'd14:   note_freq = 587;
      4'd15:   note_freq = 659;
      default: note_freq = 0;
    endcase
  endfunction

  // Terminal value of the tone counter: truncated half period minus one.
  function automatic logic [TW-1:0] half_m1(input logic [3:0] code);
    int f;
    f = note_freq(code);
    if (f == 0) half_m1 = '0;
    else        half_m1 = TW'(CLK_FREQ / (2 * f) - 1);
  endfunction

  state_t          state_q, state_d;
  logic [FW-1:0]   fetch_q, fetch_d;
  logic            chk_q, chk_d;
  logic [3:0]      pitch_q, pitch_d;
  logic [4:0]      beats_q, beats_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   tone_cnt_q, tone_cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            tone_q, tone_d;
  logic            done_q, done_d;
  logic            play_q;
  logic            play_rise;
  logic            read_c, listen_c;

  // play_q follows play even through reset, so a level held high across
  // reset or across the end of a song is never mistaken for a new request.
  assign play_rise = np.play & ~play_q;

  always_comb begin
    state_d    = state_q;
    fetch_d    = fetch_q;
    chk_d      = chk_q;
    pitch_d    = pitch_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    tone_cnt_d = tone_cnt_q;
    gap_d      = gap_q;
    tone_d     = tone_q;
    done_d     = 1'b0;
    read_c     = 1'b0;
    listen_c   = 1'b0;

    case (state_q)
      IDLE: begin
        tone_d = 1'b0;
        if (play_rise && !np.stop) begin
          listen_c = 1'b1;
          fetch_d  = FW'(MEM_LAT);
          chk_d    = 1'b0;
          state_d  = FETCH;
        end
      end

      FETCH: begin
        fetch_d = fetch_q - FW'(1);
        chk_d   = 1'b0;
        if (chk_q && np.finish) begin
`ifdef NOTE_PLAYER_LOOP_EN
          // Rewind and wait a full memory latency for note 0.
          listen_c = 1'b1;
          fetch_d  = FW'(MEM_LAT);
`else
          done_d  = 1'b1;
          state_d = IDLE;
`endif
        end else if (fetch_q == FW'(1)) begin
          pitch_d    = np.note_data[7:4];
          beats_d    = (np.note_data[3:0] == 4'd0) ? 5'd16 : {1'b0, np.note_data[3:0]};
          beat_cnt_d = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
          state_d    = PLAY;
        end
      end

      PLAY: begin
        if (pitch_q != 4'd0) begin
          if (tone_cnt_q == half_m1(pitch_q)) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
          end else begin
            tone_cnt_d = tone_cnt_q + TW'(1);
          end
        end
        if (beat_cnt_q == BW'(BEAT_CYCLES - 1)) begin
          beat_cnt_d = '0;
          if (beats_q == 5'd1) begin
            tone_d  = 1'b0;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? ADVANCE : GAP;
          end else begin
            beats_d = beats_q - 5'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end

      GAP: begin
        tone_d = 1'b0;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = ADVANCE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      ADVANCE: begin
        read_c  = 1'b1;
        fetch_d = FW'(MEM_LAT);
        chk_d   = 1'b1;
        state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase

    // Abort overrides every strobe and transition decided above.
    if (state_q != IDLE && np.stop) begin
      state_d  = IDLE;
      tone_d   = 1'b0;
      chk_d    = 1'b0;
      done_d   = 1'b0;
      read_c   = 1'b0;
      listen_c = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_q    <= '0;
      chk_q      <= 1'b0;
      pitch_q    <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      tone_cnt_q <= '0;
      gap_q      <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_q    <= fetch_d;
      chk_q      <= chk_d;
      pitch_q    <= pitch_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      gap_q      <= gap_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    play_q <= np.play;
  end

  // Strobes are decoded combinationally so memory data arrives exactly
  // MEM_LAT cycles later, at the final FETCH cycle.
  assign np.read     = read_c & reset;
  assign np.listen   = listen_c & reset;
  assign np.tone_out = tone_q;
  assign np.busy     = (state_q != IDLE);
  assign np.done     = done_q;

endmodule

// File: tb/tb_note_player.sv
// tb_note_player
//   Directed bench for note_player with CLK_FREQ=1_000_000, BEAT_CYCLES=5000,
//   GAP_CYCLES=100, MEM_LAT=2. A small song memory and address counter are
//   modelled here; expected timings are hand-derived constants.
module tb_note_player;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  note_player_if m ();

  note_player #(
    .CLK_FREQ   (1_000_000),
    .BEAT_CYCLES(5000),
    .GAP_CYCLES (100),
    .MEM_LAT    (2)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .np   (m)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] rom [0:3];
  int  addr     = 0;
  int  cyc      = 0;
  int  n_read   = 0;
  int  n_listen = 0;
  int  n_done   = 0;
  logic play_v  = 1'b0;
  logic stop_v  = 1'b0;
  logic fin_pend = 1'b0;
  logic song_mode = 1'b0;

  int   t0, rel, t_rise, t_fall, t_read, n_tog, t_done, t_listen2, t_rise2;
  logic tone_prev, gap_hi, busy_lo, busy_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs after the edge, then sample outputs and update
  // the memory/address-counter model.
  task automatic step();
    @(posedge clk);
    #1;
    m.play   = play_v;
    m.stop   = stop_v;
    m.finish = fin_pend;
    fin_pend = 1'b0;
    #1;
    cyc++;
    if (m.listen === 1'b1) begin
      n_listen++;
      addr = 0;
    end
    if (m.read === 1'b1) begin
      n_read++;
      addr++;
      if (song_mode && n_read == 3) fin_pend = 1'b1;
    end
    if (m.done === 1'b1) n_done++;
    m.note_data = rom[addr & 3];
  endtask

  task automatic set_rom(input logic [7:0] v);
    for (int i = 0; i < 4; i++) rom[i] = v;
  endtask

  // Runs from the first PLAY cycle until the read strobe, recording tone
  // behaviour relative to PLAY entry.
  task automatic run_to_read(input int play_len);
    t0 = cyc; n_tog = 0; tone_prev = m.tone_out;
    t_rise = -1; t_fall = -1; t_read = -1; gap_hi = 1'b0; busy_lo = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      step();
      rel = cyc - t0;
      if (m.tone_out !== tone_prev) n_tog++;
      tone_prev = m.tone_out;
      if (m.tone_out === 1'b1 && t_rise < 0) t_rise = rel;
      if (m.tone_out === 1'b0 && t_rise >= 0 && t_fall < 0) t_fall = rel;
      if (rel >= play_len && m.tone_out !== 1'b0) gap_hi = 1'b1;
      if (m.busy !== 1'b1) busy_lo = 1'b1;
      if (m.read === 1'b1) begin
        t_read = rel;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m.play = 1'b0; m.stop = 1'b0; m.finish = 1'b0;
    set_rom(8'hA2);
    m.note_data = 8'hA2;

    // Reset state
    repeat (3) step();
    check("rst_read",   m.read,     1'b0);
    check("rst_listen", m.listen,   1'b0);
    check("rst_tone",   m.tone_out, 1'b0);
    check("rst_busy",   m.busy,     1'b0);
    check("rst_done",   m.done,     1'b0);
    rst_n = 1'b1;
    step();

    // A4, 2 beats
    play_v = 1'b1;
    step();
    check("start_listen", m.listen, 1'b1);
    check("start_busy",   m.busy,   1'b0);
    step();
    check("f1_busy",   m.busy,   1'b1);
    check("f1_listen", m.listen, 1'b0);
    step(); step();
    run_to_read(10000);
    check("a4_first_rise", t_rise, 1136);
    check("a4_first_fall", t_fall, 2272);
    check("a4_toggles",    n_tog,  8);
    check("a4_gap_low",    gap_hi, 1'b0);
    check("a4_busy",       busy_lo, 1'b0);
    check("a4_read_time",  t_read, 10100);
    step();
    check("read_width", m.read, 1'b0);
    check("read_count", n_read, 1);
    check("listen_count", n_listen, 1);

    // Stop midway through the next note
    step(); step();
    repeat (1500) step();
    check("mid_tone_high", m.tone_out, 1'b1);
    stop_v = 1'b1;
    step();
    step();
    check("stop_busy", m.busy,     1'b0);
    check("stop_tone", m.tone_out, 1'b0);
    check("stop_done", m.done,     1'b0);
    check("stop_no_read", n_read,  1);
    stop_v = 1'b0;
    repeat (3) step();
    check("held_play_idle", m.busy, 1'b0);
    check("held_play_nolisten", n_listen, 1);
    set_rom(8'h03);
    play_v = 1'b0;
    step();
    play_v = 1'b1;
    step();
    check("restart_listen", m.listen, 1'b1);

    // Rest, 3 beats
    step(); step(); step();
    run_to_read(15000);
    check("rest_toggles",  n_tog,  0);
    check("rest_no_high",  t_rise, -1);
    check("rest_read_time", t_read, 15100);

    // Reset mid-note with play held high
    step();
    set_rom(8'hA2);
    m.note_data = 8'hA2;
    step(); step();
    repeat (1200) step();
    check("pre_reset_tone", m.tone_out, 1'b1);
    rst_n = 1'b0;
    step();
    check("mrst_busy",   m.busy,     1'b0);
    check("mrst_tone",   m.tone_out, 1'b0);
    check("mrst_read",   m.read,     1'b0);
    check("mrst_listen", m.listen,   1'b0);
    check("mrst_done",   m.done,     1'b0);
    rst_n = 1'b1;
    n_listen = 0;
    repeat (3) step();
    check("post_reset_idle", m.busy, 1'b0);
    check("post_reset_nolisten", n_listen, 0);
    play_v = 1'b0;
    step();
    play_v = 1'b1;
    step();
    check("post_reset_listen", m.listen, 1'b1);
    stop_v = 1'b1;
    step(); step();
    stop_v = 1'b0;
    play_v = 1'b0;
    step();

    // Three-note song: C4 1 beat, rest 1 beat, C5 1 beat
    rom[0] = 8'h11; rom[1] = 8'h01; rom[2] = 8'hD1; rom[3] = 8'hFF;
    n_read = 0; n_listen = 0; n_done = 0;
    song_mode = 1'b1;
    play_v = 1'b1;
    step();
    check("song_listen", m.listen, 1'b1);
    t0 = cyc; n_tog = 0; tone_prev = m.tone_out;
    t_rise = -1; t_done = -1; t_listen2 = -1; t_rise2 = -1;
    busy_lo = 1'b0; busy_at_done = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      step();
      rel = cyc - t0;
      if (m.tone_out !== tone_prev) n_tog++;
      tone_prev = m.tone_out;
      if (m.tone_out === 1'b1 && t_rise < 0) t_rise = rel;
      if (m.tone_out === 1'b1 && rel > 15311 && t_rise2 < 0) t_rise2 = rel;
      if (m.listen === 1'b1 && t_listen2 < 0) t_listen2 = rel;
      if (m.done === 1'b1 && t_done < 0) begin
        t_done = rel;
        busy_at_done = m.busy;
      end
      if (m.busy !== 1'b1) busy_lo = 1'b1;
`ifdef NOTE_PLAYER_LOOP_EN
      if (rel >= 17300) break;
`else
      if (t_done >= 0) break;
`endif
    end
    check("song_first_rise", t_rise, 1911);
    check("song_reads",      n_read, 3);
`ifdef NOTE_PLAYER_LOOP_EN
    check("loop_relisten_time", t_listen2, 15310);
    check("loop_listens",   n_listen, 2);
    check("loop_no_done",   n_done,   0);
    check("loop_busy",      busy_lo,  1'b0);
    check("loop_replay_rise", t_rise2, 17221);
    stop_v = 1'b1;
    step(); step();
    check("loop_stop_busy", m.busy, 1'b0);
`else
    check("song_done_time", t_done,      15311);
    check("song_done_busy", busy_at_done, 1'b0);
    check("song_listens",   n_listen,    1);
    check("song_dones",     n_done,      1);
    check("song_toggles",   n_tog,       8);
    repeat (5) step();
    check("song_no_restart", m.busy,  1'b0);
    check("song_no_relisten", n_listen, 1);
    check("song_done_width", n_done, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Sequencer stage directly downstream of the note-address counter. Consumes the note word that song memory returns for the current address and plays it as a square wave for its encoded duration.
- Requests the next address with a one-cycle `read` strobe and rewinds the counter with a `listen` pulse.
- Ends the song when the counter reports `finish`.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; used to build the pitch half-period table.
- BEAT_CYCLES, 12_500_000, clock cycles per duration unit (one beat).
- GAP_CYCLES, 500_000, silent cycles inserted after every note (articulation gap); 0 is legal and means no gap.
- MEM_LAT, 2, cycles from a `read` or `listen` pulse until `note_data` is valid. Legal range 1..7.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- play  input  1  level; sampled only in IDLE; 1 starts playback from address 0.
- stop  input  1  level; 1 aborts playback from any state.
- note_data  input  8  memory word. [7:4] = pitch code (0 = rest); [3:0] = duration in beats (0 = 16 beats).
- finish  input  1  from address counter; 1 = last address was passed and the counter wrapped.
- read  output  1  one-cycle pulse; advances the address counter.
- listen  output  1  one-cycle pulse; rewinds the address counter to 0.
- tone_out  output  1  square-wave audio output.
- busy  output  1  1 in every state except IDLE.
- done  output  1  one-cycle pulse when the song ends normally.

Behaviour:
- Reset (reset = 0 at an edge):
  - state = IDLE.
  - read, listen, tone_out, busy and done = 0.
  - All counters = 0.
  - Reset has priority over everything, including mid-note.
- States: IDLE, FETCH, PLAY, GAP, ADVANCE.
- IDLE:
  - If play = 1 and stop = 0: pulse listen for 1 cycle, load fetch counter with MEM_LAT, go to FETCH.
  - busy = 1 from the following cycle.
- FETCH:
  - Count down MEM_LAT cycles.
  - In the first FETCH cycle after an ADVANCE, sample finish.
  - If finish = 1: go to IDLE, pulse done, and discard note_data.
  - Otherwise, when the count expires: register note_data into a pitch register and a beat register (0 -> 16), clear the beat and tone counters, go to PLAY.
- PLAY:
  - Duration:
    - Lasts exactly beats × BEAT_CYCLES cycles.
    - Beat counter counts 0..BEAT_CYCLES-1.
    - The beat register decrements on each wrap.
    - Exit to GAP when the last beat wraps.
  - Pitch table, code -> Hz:
    - 1..12 = 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494.
    - 13..15 = 523, 587, 659.
  - Tone generation:
    - HALF = CLK_FREQ/(2·f), truncated; the table is constant-evaluated from CLK_FREQ.
    - Tone counter counts 0..HALF-1.
    - tone_out toggles when the counter reaches HALF-1, so it toggles every HALF cycles.
    - The first toggle occurs HALF cycles after PLAY entry; tone_out enters PLAY at 0.
  - Pitch code 0 (rest): tone_out held 0 for the full duration.
- GAP:
  - tone_out forced to 0 on entry.
  - Lasts GAP_CYCLES cycles, then go to ADVANCE.
  - If GAP_CYCLES = 0, go from PLAY straight to ADVANCE.
- ADVANCE:
  - read = 1 for exactly 1 cycle.
  - Reload the fetch counter with MEM_LAT and go to FETCH with the finish-check flag set.
- Stop:
  - stop = 1 in any non-IDLE state -> IDLE next edge.
  - tone_out = 0 and busy = 0; done is not pulsed and read is not pulsed.
  - stop = 1 in IDLE blocks play.
  - stop and play both 1 in IDLE: stop wins.
- Pulse exclusivity: read and listen are never high together; each is high for at most 1 cycle per event.
- play held high: once a song ends (done) or is stopped, a new song starts only after play returns to 0 and rises again. Implemented with a rising-edge detector on play; no auto-restart.
- Widths:
  - Beat and gap counters are sized with $clog2 of their parameter.
  - Tone counter is sized for the largest HALF (code 1).
  - No counter overflows or wraps outside the rules above.

Optional Feature:
- NOTE_PLAYER_LOOP_EN defined:
  - When the finish check sees finish = 1, the block pulses listen, restarts FETCH from address 0 and keeps busy = 1.
  - done is never pulsed; only stop or reset ends playback.
- NOTE_PLAYER_LOOP_EN undefined: behaviour as above; the song ends with a done pulse and a return to IDLE.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=1_000_000, BEAT_CYCLES=5000, GAP_CYCLES=100, MEM_LAT=2.
- note_data=0xA2 (A4, 2 beats) -> tone_out toggles every 1136 cycles; PLAY lasts 10000 cycles; 100-cycle low gap; then a single read pulse.
- note_data=0x03 (rest, 3 beats) -> tone_out stays 0 for 15000 cycles; read pulses 15100 cycles after PLAY entry.
- Three-note song; finish driven high the cycle after the 3rd read -> exactly 3 read pulses, 1 listen pulse at start, 1 done pulse, busy falls with done.
- stop asserted midway through note 1 -> next edge IDLE, tone_out=0, busy=0, no read, no done; play re-rising restarts with a listen pulse.
- reset=0 held 1 cycle during PLAY -> all outputs 0, state IDLE; play held high across reset does not start until it toggles low then high.
- NOTE_PLAYER_LOOP_EN build with the same 3-note song -> listen re-pulses after the finish check, note 1 replays, done never asserts.
